// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared types and constants for the mips_cpu_bus simulation memory
package mips_bus_pkg;

    // Encodings match the integer WAIT_MODE parameter of ram_bus_wait_model.
    typedef enum logic [1:0] {
        WAIT_NONE   = 2'd0,
        WAIT_FIXED  = 2'd1,
        WAIT_RANDOM = 2'd2
    } wait_mode_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } ram_state_t;

endpackage

// File: rtl/bus_wait_lfsr.sv
// rtl/bus_wait_lfsr.sv - free-running 16-bit Fibonacci LFSR that sources random stall lengths
// Ports: clk (rising edge), reset_n (async active-low, loads SEED), value[15:0] (current state).
module bus_wait_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [15:0] value
);

    // Taps 16,14,13,11; shifts every clock regardless of bus traffic.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= SEED;
        end else begin
            value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
        end
    end

endmodule

// File: rtl/ram_bus_wait_model.sv
// rtl/ram_bus_wait_model.sv - parametrised Avalon-style simulation RAM with programmable waitrequest stalls
// Ports: clk, reset_n (async active-low); address/write/read/writedata/byteenable from the bus master;
//        waitrequest (combinational stall), readdata (registered), bus_error (sticky violation flag).
module ram_bus_wait_model
    import mips_bus_pkg::*;
#(
    parameter string       RAM_INIT_FILE = "",
    parameter int          DEPTH_LOG2    = 12,
    parameter logic [31:0] BASE_ADDR     = RESET_VECTOR,
    parameter int          WAIT_MODE     = 0,
    parameter int          WAIT_CYCLES   = 1,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address,
    input  logic        write,
    input  logic        read,
    output logic        waitrequest,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        bus_error
);

    localparam int WORDS = 1 << DEPTH_LOG2;

    logic [31:0]           mem [WORDS];
    ram_state_t            state, next_state;
    logic [3:0]            cnt, next_cnt, load_cnt;
    logic [15:0]           lfsr_value;
    logic                  lfsr_unused;
    logic                  req, changed, abort, complete;
    logic                  in_range, misaligned;
    logic [31:0]           addr_aligned, offset;
    logic [DEPTH_LOG2-1:0] idx;
    logic [31:0]           lat_address, lat_writedata;
    logic [3:0]            lat_byteenable;

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 32'h0;
    end

    bus_wait_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .value   (lfsr_value)
    );

    assign lfsr_unused  = ^lfsr_value[15:4];
    assign req          = read | write;
    assign misaligned   = address[1:0] != 2'b00;
    assign addr_aligned = {address[31:2], 2'b00};
    assign offset       = addr_aligned - BASE_ADDR;
    assign in_range     = (addr_aligned >= BASE_ADDR) && ((offset >> (DEPTH_LOG2 + 2)) == 32'd0);
    assign idx          = offset[DEPTH_LOG2+1:2];

    // Any change of the held request while stalled is a master protocol violation.
    assign changed = (address != lat_address) || (writedata != lat_writedata) ||
                     (byteenable != lat_byteenable);

    always_comb begin
        load_cnt = 4'd0;
        if (WAIT_MODE == int'(WAIT_FIXED)) begin
            load_cnt = 4'(WAIT_CYCLES);
        end else if (WAIT_MODE == int'(WAIT_RANDOM)) begin
            load_cnt = 4'(5'(lfsr_value[3:0]) % 5'(WAIT_CYCLES + 1));
        end
    end

    // The IDLE request cycle is itself the first stall cycle, so STALL is
    // entered with load-1 and completes when the counter reaches zero.
    always_comb begin
        next_state  = state;
        next_cnt    = cnt;
        waitrequest = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (req && load_cnt != 4'd0) begin
                    waitrequest = 1'b1;
                    next_state  = STALL;
                    next_cnt    = load_cnt - 4'd1;
                end
            end
            STALL: begin
                if (!req || changed) begin
                    abort       = 1'b1;
                    waitrequest = req;
                    next_state  = IDLE;
                    next_cnt    = 4'd0;
                end else if (cnt == 4'd0) begin
                    next_state = IDLE;
                end else begin
                    waitrequest = 1'b1;
                    next_cnt    = cnt - 4'd1;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 4'd0;
            end
        endcase
        if (!reset_n) waitrequest = 1'b0;
    end

    // Gating with reset_n keeps a held request from completing while reset is low.
    assign complete = reset_n && req && !waitrequest && !abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            readdata       <= 32'h0;
            bus_error      <= 1'b0;
            lat_address    <= 32'h0;
            lat_writedata  <= 32'h0;
            lat_byteenable <= 4'h0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (state == IDLE && next_state == STALL) begin
                lat_address    <= address;
                lat_writedata  <= writedata;
                lat_byteenable <= byteenable;
            end
            if (complete && !write) readdata <= in_range ? mem[idx] : 32'h0;
            if ((complete && (!in_range || misaligned || (read && write))) || abort) begin
                bus_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (complete && write && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) mem[idx][8*i +: 8] <= writedata[8*i +: 8];
            end
        end
    end

    always @(posedge clk) begin
        if (complete && read && write) $error("ram_bus_wait_model: read and write asserted together");
        if (complete && misaligned) $error("ram_bus_wait_model: unaligned address %h", address);
        if (reset_n && abort) $error("ram_bus_wait_model: request dropped or changed during stall");
    end

endmodule

// File: tb/tb_ram_bus_wait_model.sv
// tb/tb_ram_bus_wait_model.sv - directed self-checking bench for ram_bus_wait_model
module tb_ram_bus_wait_model;

    logic        clk = 1'b0;
    logic [3:0]  reset_n = 4'b0000;
    logic [31:0] address    [4];
    logic [31:0] writedata  [4];
    logic [3:0]  byteenable [4];
    logic [3:0]  write = 4'b0000;
    logic [3:0]  read  = 4'b0000;
    logic [31:0] rd0, rd1, rd2, rd3;
    logic        wq0, wq1, wq2, wq3;
    logic        er0, er1, er2, er3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // k=0 no wait, k=1 fixed 3, k=2 random 0..7, k=3 fixed 4
    ram_bus_wait_model #(.WAIT_MODE(0), .WAIT_CYCLES(1)) u_m0 (
        .clk(clk), .reset_n(reset_n[0]), .address(address[0]), .write(write[0]), .read(read[0]),
        .waitrequest(wq0), .writedata(writedata[0]), .byteenable(byteenable[0]),
        .readdata(rd0), .bus_error(er0));
    ram_bus_wait_model #(.WAIT_MODE(1), .WAIT_CYCLES(3)) u_m1 (
        .clk(clk), .reset_n(reset_n[1]), .address(address[1]), .write(write[1]), .read(read[1]),
        .waitrequest(wq1), .writedata(writedata[1]), .byteenable(byteenable[1]),
        .readdata(rd1), .bus_error(er1));
    ram_bus_wait_model #(.WAIT_MODE(2), .WAIT_CYCLES(7)) u_m2 (
        .clk(clk), .reset_n(reset_n[2]), .address(address[2]), .write(write[2]), .read(read[2]),
        .waitrequest(wq2), .writedata(writedata[2]), .byteenable(byteenable[2]),
        .readdata(rd2), .bus_error(er2));
    ram_bus_wait_model #(.WAIT_MODE(1), .WAIT_CYCLES(4)) u_m3 (
        .clk(clk), .reset_n(reset_n[3]), .address(address[3]), .write(write[3]), .read(read[3]),
        .waitrequest(wq3), .writedata(writedata[3]), .byteenable(byteenable[3]),
        .readdata(rd3), .bus_error(er3));

    function automatic logic [31:0] rdata(input int k);
        case (k)
            0: return rd0;
            1: return rd1;
            2: return rd2;
            default: return rd3;
        endcase
    endfunction

    function automatic logic wreq(input int k);
        case (k)
            0: return wq0;
            1: return wq1;
            2: return wq2;
            default: return wq3;
        endcase
    endfunction

    function automatic logic berr(input int k);
        case (k)
            0: return er0;
            1: return er1;
            2: return er2;
            default: return er3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transfer; returns the number of cycles waitrequest was seen high.
    task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, output int stalls);
        @(negedge clk);
        address[k]    = a;
        writedata[k]  = wd;
        byteenable[k] = be;
        write[k]      = wr;
        read[k]       = ~wr;
        stalls        = 0;
        #1;
        while (wreq(k) && stalls < 40) begin
            stalls++;
            @(posedge clk);
            #1;
        end
        if (stalls >= 40) check("wait_bound", 32'(wreq(k)), 32'd0);
        @(posedge clk);
        #1;
        write[k] = 1'b0;
        read[k]  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int max_st;
        logic [31:0] sb [16];
        logic [31:0] d;
        logic [3:0]  be;
        int w;
        bit wr;

        for (int k = 0; k < 4; k++) begin
            address[k] = 32'h0; writedata[k] = 32'h0; byteenable[k] = 4'h0;
        end
        for (int i = 0; i < 16; i++) sb[i] = 32'h0;

        // Reset state
        #12;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_readdata%0d", k), rdata(k), 32'h0);
            check($sformatf("rst_wait%0d", k), 32'(wreq(k)), 32'd0);
            check($sformatf("rst_err%0d", k), 32'(berr(k)), 32'd0);
        end
        @(negedge clk);
        reset_n = 4'b1111;

        // Test 1: zero-wait mode, preload through the bus then read back
        xfer(0, 1, 32'hBFC00004, 32'h12345678, 4'hF, st);
        check("m0_wr_stalls", st, 0);
        xfer(0, 1, 32'hBFC00000, 32'hA5A50001, 4'hF, st);
        xfer(0, 0, 32'hBFC00004, 32'h0, 4'h0, st);
        check("m0_rd_stalls", st, 0);
        check("m0_rd_data", rd0, 32'h12345678);

        // Zero-wait back-to-back reads, one per cycle
        @(negedge clk);
        address[0] = 32'hBFC00000; read[0] = 1'b1;
        #1 check("b2b_wait_a", 32'(wq0), 32'd0);
        @(posedge clk);
        #1 check("b2b_data_a", rd0, 32'hA5A50001);
        address[0] = 32'hBFC00004;
        #1 check("b2b_wait_b", 32'(wq0), 32'd0);
        @(posedge clk);
        #1 check("b2b_data_b", rd0, 32'h12345678);
        read[0] = 1'b0;
        check("m0_err_clean", 32'(er0), 32'd0);

        // Test 2: fixed 3-cycle stalls
        xfer(1, 1, 32'hBFC00008, 32'hDEADBEEF, 4'hF, st);
        check("m1_wr_stalls", st, 3);
        xfer(1, 0, 32'hBFC00008, 32'h0, 4'h0, st);
        check("m1_rd_stalls", st, 3);
        check("m1_rd_data", rd1, 32'hDEADBEEF);

        // Test 3: byte-lane merges
        xfer(1, 1, 32'hBFC00008, 32'h000000AA, 4'b0001, st);
        xfer(1, 0, 32'hBFC00008, 32'h0, 4'h0, st);
        check("be_lane0", rd1, 32'hDEADBEAA);
        xfer(1, 1, 32'hBFC00008, 32'hFFFFFFFF, 4'b0000, st);
        xfer(1, 0, 32'hBFC00008, 32'h0, 4'h0, st);
        check("be_none", rd1, 32'hDEADBEAA);
        xfer(1, 1, 32'hBFC00008, 32'h00550000, 4'b0100, st);
        xfer(1, 0, 32'hBFC00008, 32'h0, 4'h0, st);
        check("be_lane2", rd1, 32'hDE55BEAA);
        check("m1_err_clean", 32'(er1), 32'd0);

        // Test 4: random stalls against a scoreboard
        max_st = 0;
        for (int n = 0; n < 200; n++) begin
            wr = 1'($urandom_range(0, 1));
            w  = $urandom_range(0, 15);
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            xfer(2, wr, 32'hBFC00000 + 32'(w * 4), d, be, st);
            check("m2_stall_range", 32'(st <= 7), 32'd1);
            if (st > max_st) max_st = st;
            if (wr) begin
                for (int i = 0; i < 4; i++) if (be[i]) sb[w][8*i +: 8] = d[8*i +: 8];
            end else begin
                check($sformatf("m2_rd_w%0d", w), rd2, sb[w]);
            end
        end
        check("m2_some_stall", 32'(max_st > 0), 32'd1);
        check("m2_err_clean", 32'(er2), 32'd0);

        // Test 5: out-of-range accesses, then reset clears the flag
        xfer(0, 0, 32'h00000000, 32'h0, 4'h0, st);
        check("oor_low_data", rd0, 32'h0);
        check("oor_err", 32'(er0), 32'd1);
        xfer(0, 0, 32'hBFC00004, 32'h0, 4'h0, st);
        xfer(0, 0, 32'hBFC04000, 32'h0, 4'h0, st);
        check("oor_high_data", rd0, 32'h0);
        @(negedge clk);
        reset_n[0] = 1'b0;
        #1 check("rst_err_async", 32'(er0), 32'd0);
        check("rst_rd_async", rd0, 32'h0);
        @(negedge clk);
        reset_n[0] = 1'b1;
        xfer(0, 0, 32'hBFC00004, 32'h0, 4'h0, st);
        check("mem_kept", rd0, 32'h12345678);

        // Test 6: reset during stall cycle 2 of a write
        xfer(3, 1, 32'hBFC00010, 32'h11111111, 4'hF, st);
        check("m3_wr_stalls", st, 4);
        @(negedge clk);
        address[3] = 32'hBFC00010; writedata[3] = 32'h22222222; byteenable[3] = 4'hF; write[3] = 1'b1;
        #1 check("abort_stall1", 32'(wq3), 32'd1);
        @(posedge clk);
        #1 check("abort_stall2", 32'(wq3), 32'd1);
        reset_n[3] = 1'b0;
        #1 check("abort_wait_low", 32'(wq3), 32'd0);
        write[3] = 1'b0;
        @(negedge clk);
        reset_n[3] = 1'b1;
        xfer(3, 0, 32'hBFC00010, 32'h0, 4'h0, st);
        check("abort_rd_stalls", st, 4);
        check("abort_word_kept", rd3, 32'h11111111);
        check("m3_err_clean", 32'(er3), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
